// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART controller.
// UART_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } uart_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int tick_div(input int clk_hz, input int baud, input int over_samp);
    return clk_hz / (baud * over_samp);
  endfunction

endpackage

// File: rtl/uart_if.sv
// Host-side byte stream bundle: TX push handshake and RX pop handshake.
interface uart_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART transmitter/receiver with TX and RX FIFOs and sticky error flags.
// Define UART_PARITY_EN to add a parity bit (odd when PARITY_ODD=1) on both directions.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 460800,
  parameter int OVER_SAMP  = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  uart_rxd,
  output logic  uart_txd,
  uart_if.slave bus,
  output logic  err_frame,
  output logic  err_parity,
  output logic  err_overrun,
  input  logic  err_clear,
  output logic  tx_busy
);

  localparam int DIV  = tick_div(CLK_FREQ, BAUD_RATE, OVER_SAMP);
  localparam int TW   = clog2(DIV + 1);
  localparam int OSW  = clog2(OVER_SAMP);
  localparam int BW   = clog2(DATA_BITS + 1);
  localparam int HALF = OVER_SAMP / 2;
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVER_SAMP - 1);

  if (DIV < 1) begin : g_div_chk
    $error("uart_ctrl: CLK_FREQ too low for BAUD_RATE*OVER_SAMP");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_chk
    $error("uart_ctrl: illegal frame format parameters");
  end

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TW'(DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_full, rx_empty, rx_wr;
  logic [DATA_BITS-1:0] rx_head;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.tx_valid && bus.tx_ready),
    .wr_data (bus.tx_data),
    .full    (tx_full),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty)
  );

  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rx_wr && !rx_full),
    .wr_data (rx_sh_q),
    .full    (rx_full),
    .rd_en   (bus.rx_valid && bus.rx_ready),
    .rd_data (rx_head),
    .empty   (rx_empty)
  );

  assign bus.tx_ready = !tx_full;
  assign bus.rx_valid = !rx_empty;
  assign bus.rx_data  = rx_head;

  uart_state_e          tx_state_q, tx_state_d;
  logic [OSW-1:0]       tx_os_q, tx_os_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 txd_q, txd_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tick) begin
      // The last stop tick chains straight into the next start bit when data is waiting.
      if (tx_state_q == ST_IDLE ||
          (tx_state_q == ST_STOP && tx_os_q == OS_LAST && tx_bit_q == BW'(STOP_BITS - 1))) begin
        tx_os_d  = '0;
        tx_bit_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_state_d = ST_START;
          txd_d      = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = (^tx_head) ^ 1'(PARITY_ODD);
`endif
        end else begin
          tx_state_d = ST_IDLE;
          txd_d      = 1'b1;
        end
      end else if (tx_os_q != OS_LAST) begin
        tx_os_d = tx_os_q + 1'b1;
      end else begin
        tx_os_d = '0;
        case (tx_state_q)
          ST_START: begin
            tx_state_d = ST_DATA;
            tx_bit_d   = '0;
            txd_d      = tx_sh_q[0];
          end
          ST_DATA: begin
            if (tx_bit_q == BW'(DATA_BITS - 1)) begin
              tx_bit_d   = '0;
`ifdef UART_PARITY_EN
              tx_state_d = ST_PARITY;
              txd_d      = tx_par_q;
`else
              tx_state_d = ST_STOP;
              txd_d      = 1'b1;
`endif
            end else begin
              tx_bit_d = tx_bit_q + 1'b1;
              tx_sh_d  = tx_sh_q >> 1;
              txd_d    = tx_sh_q[1];
            end
          end
`ifdef UART_PARITY_EN
          ST_PARITY: begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end
`endif
          ST_STOP: begin
            tx_bit_d = tx_bit_q + 1'b1;
            txd_d    = 1'b1;
          end
          default: tx_state_d = ST_IDLE;
        endcase
      end
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = (tx_state_q != ST_IDLE) || !tx_empty;

  logic           rxd_meta_q, rxd_sync_q, rxd_prev_q;
  uart_state_e    rx_state_q, rx_state_d;
  logic [OSW-1:0] rx_os_q, rx_os_d;
  logic [BW-1:0]  rx_bit_q, rx_bit_d;
  logic [1:0]     rx_ones_q, rx_ones_d, ones_sum;
  logic           vote, set_frame, set_parity, set_overrun;
`ifdef UART_PARITY_EN
  logic           rx_perr_q, rx_perr_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_ones_d  = rx_ones_q;
    rx_wr      = 1'b0;
    set_frame  = 1'b0;
    set_parity = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    // Third sample completes the 2-of-3 vote.
    ones_sum   = rx_ones_q + {1'b0, rxd_sync_q};
    vote       = ones_sum[1];
    if (rx_state_q == ST_IDLE) begin
      if (rxd_prev_q && !rxd_sync_q) begin
        rx_state_d = ST_START;
        rx_os_d    = '0;
        rx_bit_d   = '0;
        rx_ones_d  = '0;
      end
    end else if (tick) begin
      rx_os_d = (rx_os_q == OS_LAST) ? '0 : rx_os_q + 1'b1;
      if (rx_os_q == OSW'(HALF - 1)) begin
        rx_ones_d = {1'b0, rxd_sync_q};
      end else if (rx_os_q == OSW'(HALF)) begin
        rx_ones_d = ones_sum;
      end else if (rx_os_q == OSW'(HALF + 1)) begin
        case (rx_state_q)
          ST_START: if (vote) rx_state_d = ST_IDLE;
          ST_DATA:  rx_sh_d = {vote, rx_sh_q[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
          ST_PARITY: rx_perr_d = vote ^ (^rx_sh_q) ^ 1'(PARITY_ODD);
`endif
          ST_STOP: begin
            rx_wr      = 1'b1;
            set_frame  = !vote;
`ifdef UART_PARITY_EN
            set_parity = rx_perr_q;
`endif
            rx_state_d = ST_IDLE;
          end
          default: ;
        endcase
      end else if (rx_os_q == OS_LAST) begin
        case (rx_state_q)
          ST_START: begin
            rx_state_d = ST_DATA;
            rx_bit_d   = '0;
          end
          ST_DATA: begin
            if (rx_bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_d = ST_PARITY;
`else
              rx_state_d = ST_STOP;
`endif
            end else begin
              rx_bit_d = rx_bit_q + 1'b1;
            end
          end
`ifdef UART_PARITY_EN
          ST_PARITY: rx_state_d = ST_STOP;
`endif
          default: ;
        endcase
      end
    end
  end

  assign set_overrun = rx_wr && rx_full;

  logic err_frame_q, err_frame_d, err_overrun_q, err_overrun_d;
  logic err_parity_q, err_parity_d;

  // A flag being set in the same cycle as err_clear stays set.
  always_comb begin
    err_frame_d   = set_frame   ? 1'b1 : (err_clear ? 1'b0 : err_frame_q);
    err_overrun_d = set_overrun ? 1'b1 : (err_clear ? 1'b0 : err_overrun_q);
    err_parity_d  = set_parity  ? 1'b1 : (err_clear ? 1'b0 : err_parity_q);
  end

  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;
`ifdef UART_PARITY_EN
  assign err_parity  = err_parity_q;
`else
  assign err_parity  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q    <= '0;
      tx_state_q    <= ST_IDLE;
      tx_os_q       <= '0;
      tx_bit_q      <= '0;
      txd_q         <= 1'b1;
      rxd_meta_q    <= 1'b1;
      rxd_sync_q    <= 1'b1;
      rxd_prev_q    <= 1'b1;
      rx_state_q    <= ST_IDLE;
      rx_os_q       <= '0;
      rx_bit_q      <= '0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_parity_q  <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      tx_state_q    <= tx_state_d;
      tx_os_q       <= tx_os_d;
      tx_bit_q      <= tx_bit_d;
      txd_q         <= txd_d;
      rxd_meta_q    <= uart_rxd;
      rxd_sync_q    <= rxd_meta_q;
      rxd_prev_q    <= rxd_sync_q;
      rx_state_q    <= rx_state_d;
      rx_os_q       <= rx_os_d;
      rx_bit_q      <= rx_bit_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
      err_parity_q  <= err_parity_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh_q   <= tx_sh_d;
    rx_sh_q   <= rx_sh_d;
    rx_ones_q <= rx_ones_d;
`ifdef UART_PARITY_EN
    tx_par_q  <= tx_par_d;
    rx_perr_q <= rx_perr_d;
`endif
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl at 625 kbaud / 100 MHz (DIV=10, 160 clk per bit).
// Parity scenarios are compiled in with UART_PARITY_EN.
module tb_uart_ctrl;

  localparam int BIT_CLK = 160;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd, rxd;
  logic drv_rxd = 1'b1;
  logic loop = 1'b0;
  logic err_frame, err_parity, err_overrun, err_clear, tx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign rxd = loop ? txd : drv_rxd;

  uart_if #(.DATA_BITS(8)) bus ();

  uart_ctrl #(
    .CLK_FREQ   (100_000_000),
    .BAUD_RATE  (625000),
    .OVER_SAMP  (16),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .FIFO_DEPTH (16),
    .PARITY_ODD (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rxd    (rxd),
    .uart_txd    (txd),
    .bus         (bus),
    .err_frame   (err_frame),
    .err_parity  (err_parity),
    .err_overrun (err_overrun),
    .err_clear   (err_clear),
    .tx_busy     (tx_busy)
  );

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_d(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    int k;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    k = 0;
    while (!bus.tx_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) check_b("push_ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_b({tag, "_valid"}, bus.rx_valid, 1'b1);
    check_d({tag, "_data"}, bus.rx_data, exp);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    drv_rxd = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    drv_rxd = 1'b1;
  endtask

  task automatic wait_tx_idle(input string tag);
    int k;
    k = 0;
    while (tx_busy && k < 40000) begin
      @(negedge clk);
      k++;
    end
    check_b(tag, tx_busy, 1'b0);
  endtask

  initial begin
    logic [7:0] a5;
    logic       found;
    int         k;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    err_clear    = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check_b("rst_txd", txd, 1'b1);
    check_b("rst_tx_ready", bus.tx_ready, 1'b1);
    check_b("rst_rx_valid", bus.rx_valid, 1'b0);
    check_b("rst_tx_busy", tx_busy, 1'b0);
    check_b("rst_err_frame", err_frame, 1'b0);
    check_b("rst_err_parity", err_parity, 1'b0);
    check_b("rst_err_overrun", err_overrun, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single 0xA5 frame on the line
    a5 = 8'hA5;
    push(a5);
    check_b("a5_busy_after_push", tx_busy, 1'b1);
    found = 1'b0;
    k = 0;
    while (!found && k < 100) begin
      if (txd == 1'b0) found = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check_b("a5_start_seen", found, 1'b1);
    repeat (BIT_CLK / 2) @(negedge clk);
    check_b("a5_start_bit", txd, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CLK) @(negedge clk);
      check_b($sformatf("a5_data_bit%0d", i), txd, a5[i]);
    end
`ifdef UART_PARITY_EN
    repeat (BIT_CLK) @(negedge clk);
    check_b("a5_parity_bit", txd, 1'b0);
`endif
    repeat (BIT_CLK) @(negedge clk);
    check_b("a5_stop_bit", txd, 1'b1);
    repeat (BIT_CLK / 2 - 1) @(negedge clk);
    check_b("a5_busy_before_end", tx_busy, 1'b1);
    @(negedge clk);
    check_b("a5_busy_at_end", tx_busy, 1'b0);
    check_b("a5_txd_idle", txd, 1'b1);
    check_b("a5_no_rx", bus.rx_valid, 1'b0);

    // Loopback of three back-to-back bytes
    loop = 1'b1;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    wait_tx_idle("loop_tx_done");
    repeat (200) @(negedge clk);
    pop_check("loop0", 8'h00);
    pop_check("loop1", 8'hFF);
    pop_check("loop2", 8'h55);
    check_b("loop_empty", bus.rx_valid, 1'b0);
    check_b("loop_err_frame", err_frame, 1'b0);
    check_b("loop_err_overrun", err_overrun, 1'b0);
    check_b("loop_err_parity", err_parity, 1'b0);
    loop = 1'b0;

    // 80-clk glitch must not start a frame
    repeat (50) @(negedge clk);
    drv_rxd = 1'b0;
    repeat (80) @(negedge clk);
    drv_rxd = 1'b1;
    repeat (2 * NBITS * BIT_CLK) @(negedge clk);
    check_b("glitch_no_rx", bus.rx_valid, 1'b0);
    check_b("glitch_err_frame", err_frame, 1'b0);

    // 0x3C with a zero stop bit
    send_frame(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    check_b("frm_err_frame", err_frame, 1'b1);
    check_b("frm_err_overrun", err_overrun, 1'b0);
    pop_check("frm", 8'h3C);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check_b("frm_cleared", err_frame, 1'b0);

    // Seventeen frames into a 16-entry RX FIFO
    loop = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    wait_tx_idle("ovr_tx_done");
    repeat (200) @(negedge clk);
    check_b("ovr_err_overrun", err_overrun, 1'b1);
    check_b("ovr_err_frame", err_frame, 1'b0);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovr%0d", i), 8'(8'h10 + i));
    check_b("ovr_dropped", bus.rx_valid, 1'b0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check_b("ovr_cleared", err_overrun, 1'b0);
    loop = 1'b0;

`ifdef UART_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(a5[i] & 1'b0 | ((8'h07 >> i) & 8'h01) != 0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (200) @(negedge clk);
    check_b("par_bad_flag", err_parity, 1'b1);
    pop_check("par_bad", 8'h07);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check_b("par_cleared", err_parity, 1'b0);
    send_frame(8'h07, 1'b1);
    repeat (200) @(negedge clk);
    check_b("par_good_flag", err_parity, 1'b0);
    pop_check("par_good", 8'h07);
`endif

    // Reset in the middle of a looped frame
    loop = 1'b1;
    push(8'h96);
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_b("midrst_txd", txd, 1'b1);
    check_b("midrst_busy", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (NBITS * BIT_CLK + 200) @(negedge clk);
    check_b("midrst_txd_after", txd, 1'b1);
    check_b("midrst_busy_after", tx_busy, 1'b0);
    check_b("midrst_no_rx", bus.rx_valid, 1'b0);
    check_b("midrst_err_frame", err_frame, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
